// File: rtl/ca4_q8_serial_to_parallel.sv
// Serial-to-parallel receiver: MSB-first words on a valid/ready register with sticky overrun.
// Optional even-parity trailer bit enabled by defining CA4_S2P_PARITY_EN.
module ca4_q8_serial_to_parallel #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rs,
   input  logic             clr,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] bit_cnt,
   output logic             overrun,
   output logic             parity_err
);

`ifdef CA4_S2P_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               valid_q, valid_d;
   logic               ovr_q, ovr_d;
   logic               done;
`ifdef CA4_S2P_PARITY_EN
   logic               perr_q, perr_d;
`endif

   always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef CA4_S2P_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
`ifdef CA4_S2P_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      done    = 1'b0;
`ifdef CA4_S2P_PARITY_EN
      perr_d  = perr_q;
`endif

      if (valid_q && dout_ready) valid_d = 1'b0;

      if (clr) begin
         state_d = IDLE;
         sr_d    = '0;
         cnt_d   = '0;
         ovr_d   = 1'b0;
      end else if (din_en) begin
         case (state_q)
            IDLE: begin
               sr_d    = {sr_q[WIDTH-2:0], din};
               cnt_d   = CNT_W'(1);
               state_d = SHIFT;
            end
            SHIFT: begin
               if (cnt_q == LAST) begin
                  done = 1'b1;
               end else begin
                  sr_d  = {sr_q[WIDTH-2:0], din};
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Completion overrides the ready-driven clear so a word taken on this edge is replaced, not lost.
      if (done) begin
`ifdef CA4_S2P_PARITY_EN
         dout_d = sr_q;
         perr_d = ^{sr_q, din};
`else
         dout_d = {sr_q[WIDTH-2:0], din};
`endif
         valid_d = 1'b1;
         if (valid_q && !dout_ready) ovr_d = 1'b1;
         sr_d    = '0;
         cnt_d   = '0;
         state_d = IDLE;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign bit_cnt    = cnt_q;
   assign overrun    = ovr_q;
`ifdef CA4_S2P_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ca4_q8_serial_to_parallel.sv
// Self-checking bench for ca4_q8_serial_to_parallel: randomized traffic against a bit-queue model
// plus directed literal scenarios.
module tb_ca4_q8_serial_to_parallel;

`ifdef CA4_S2P_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FRAME = 8 + int'(PAR);

   logic       clk = 1'b0;
   logic       rs, clr, din, din_en, dout_ready;
   logic [7:0] dout;
   logic       dout_valid, overrun, parity_err;
   logic [3:0] bit_cnt;

   ca4_q8_serial_to_parallel #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .rs(rs), .clr(clr), .din(din), .din_en(din_en),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .bit_cnt(bit_cnt), .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   bit done_flag = 1'b0;

   bit         m_bits[$];
   logic [7:0] m_dout;
   bit         m_valid, m_ovr, m_perr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
   endtask

   // Model step: operates on the inputs present at the edge just taken.
   task automatic model_step();
      bit         nv;
      logic [7:0] w;
      bit         px;
      if (!rs) return;
      nv = m_valid;
      if (m_valid && dout_ready) nv = 0;
      if (clr) begin
         m_bits.delete();
         m_ovr = 0;
      end else if (din_en) begin
         m_bits.push_back(din);
         if (m_bits.size() == FRAME) begin
            w = '0; px = 0;
            for (int i = 0; i < 8; i++) w = {w[6:0], m_bits[i]};
            for (int i = 0; i < FRAME; i++) px = px ^ m_bits[i];
            m_dout = w;
            if (PAR) m_perr = px;
            if (m_valid && !dout_ready) m_ovr = 1;
            nv = 1;
            m_bits.delete();
         end
      end
      m_valid = nv;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic strobe(input bit b, input bit rdy);
      din = b; din_en = 1; dout_ready = rdy;
      tick();
      din_en = 0; dout_ready = 0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit last_rdy, input bit bad_par);
      for (int i = 7; i >= 0; i--) strobe(w[i], (!PAR && i == 0) ? last_rdy : 1'b0);
      if (PAR) strobe((^w) ^ bad_par, last_rdy);
   endtask

   always @(negedge clk) begin
      if (!done_flag) begin
         chk("cyc_dout",       32'(dout),       32'(m_dout));
         chk("cyc_dout_valid", 32'(dout_valid), 32'(m_valid));
         chk("cyc_bit_cnt",    32'(bit_cnt),    32'(m_bits.size()));
         chk("cyc_overrun",    32'(overrun),    32'(m_ovr));
         chk("cyc_parity_err", 32'(parity_err), 32'(m_perr));
      end
   end

   initial begin
      rs = 0; clr = 0; din = 0; din_en = 0; dout_ready = 0;
      model_reset();
      #1;
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_valid", 32'(dout_valid), 32'h0);
      tick(); tick();
      rs = 1;

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         din        = 1'($urandom);
         din_en     = ($urandom_range(0, 2) != 0);
         dout_ready = ($urandom_range(0, 3) == 0);
         clr        = ($urandom_range(0, 63) == 0);
         tick();
      end
      clr = 0; din_en = 0; dout_ready = 0;

      // 1: reset mid-frame, then A5
      strobe(1, 0); strobe(1, 0); strobe(0, 0);
      #2 rs = 0; model_reset();
      #1;
      chk("t1_rst_dout", 32'(dout), 32'h0);
      chk("t1_rst_valid", 32'(dout_valid), 32'h0);
      chk("t1_rst_cnt", 32'(bit_cnt), 32'h0);
      chk("t1_rst_ovr", 32'(overrun), 32'h0);
      chk("t1_rst_perr", 32'(parity_err), 32'h0);
      tick();
      rs = 1;
      send_word(8'hA5, 0, 0);
      chk("t1_dout", 32'(dout), 32'hA5);
      chk("t1_valid", 32'(dout_valid), 32'h1);
      chk("t1_cnt", 32'(bit_cnt), 32'h0);

      // 2: overrun then clr
      dout_ready = 1; tick(); dout_ready = 0;
      send_word(8'h3C, 0, 0);
      chk("t2_first", 32'(dout), 32'h3C);
      send_word(8'hF0, 0, 0);
      chk("t2_dout", 32'(dout), 32'hF0);
      chk("t2_ovr", 32'(overrun), 32'h1);
      chk("t2_valid", 32'(dout_valid), 32'h1);
      clr = 1; tick(); clr = 0;
      chk("t2_clr_ovr", 32'(overrun), 32'h0);
      chk("t2_clr_dout", 32'(dout), 32'hF0);
      chk("t2_clr_valid", 32'(dout_valid), 32'h1);

      // 3: completion coinciding with ready while F0 pending
      send_word(8'h81, 1, 0);
      chk("t3_dout", 32'(dout), 32'h81);
      chk("t3_valid", 32'(dout_valid), 32'h1);
      chk("t3_ovr", 32'(overrun), 32'h0);
      dout_ready = 1; tick(); dout_ready = 0;
      chk("t3_taken", 32'(dout_valid), 32'h0);

      // 4: clr with din_en discards partial frame
      strobe(1, 0); strobe(0, 0); strobe(1, 0);
      chk("t4_cnt3", 32'(bit_cnt), 32'h3);
      clr = 1; din = 1; din_en = 1; tick(); clr = 0; din_en = 0;
      chk("t4_cnt0", 32'(bit_cnt), 32'h0);
      send_word(8'h55, 0, 0);
      chk("t4_dout", 32'(dout), 32'h55);

      // 5: gapped strobes
      begin
         logic [7:0] gw;
         gw = 8'h96;
         for (int i = 7; i >= 0; i--) begin
            repeat ($urandom_range(0, 3)) tick();
            strobe(gw[i], 0);
            chk("t5_cnt", 32'(bit_cnt), (i == 0 && !PAR) ? 32'h0 : 32'(8 - i));
            tick();
         end
         if (PAR) strobe(^gw, 0);
         chk("t5_dout", 32'(dout), 32'h96);
      end

`ifdef CA4_S2P_PARITY_EN
      // 6: parity
      send_word(8'hA5, 0, 0);
      chk("t6_good", 32'(parity_err), 32'h0);
      send_word(8'hA5, 0, 1);
      chk("t6_bad", 32'(parity_err), 32'h1);
      chk("t6_dout", 32'(dout), 32'hA5);
`endif

      tick(); tick();
      done_flag = 1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
